kb_event_ctrl: RTL and testbench
================================

Name: kb_event_ctrl

Overview:
- Sequences the PS/2 keyboard decoder output (key code, ASCII, key-valid level) into a buffered event stream for the MIPS CPU's memory-mapped keyboard port.
- Detects key-press edges, schedules typematic auto-repeat while a key is held, and queues events in a FIFO that the CPU drains with a pop handshake.
- Sits between the keyboard decoder and the CPU I/O bus decode.

Parameters:
- DEPTH, 16, FIFO entries; power of two, >= 2.
- DELAY_CYC, 25000000, clk cycles from first press to first repeat (0.5 s at 50 MHz); >= 2.
- PERIOD_CYC, 5000000, clk cycles between repeats (100 ms at 50 MHz); >= 2.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- key_code  in  8  current key code from the keyboard decoder.
- key_ascii  in  8  ASCII for key_code; valid one cycle after key_code changes (synchronous ROM).
- key_en  in  1  high while a printable, non-modifier key is held.
- rd_en  in  1  CPU pop request, one-cycle pulse.
- rd_data  out  16  head entry {code[15:8], ascii[7:0]}; show-ahead, valid when empty=0.
- empty  out  1  FIFO empty.
- full  out  1  FIFO full.
- count  out  $clog2(DEPTH)+1  number of stored entries.
- overflow  out  1  sticky; an event was dropped.
- clr_ovf  in  1  clears overflow.

Behaviour:
- Reset: FIFO emptied, count=0, empty=1, full=0, overflow=0, rd_data=0, FSM=IDLE, registered key_en=0, registered code=0, counter=0, pending=0.
- Detection uses registered key_en_q/code_q:
  - press = key_en && (!key_en_q || key_code != code_q)
  - release = !key_en && key_en_q
- A key still held across reset produces one press event on the first cycle after rst deasserts.
- Push pipeline: press in cycle N sets pending and latches code. In N+1, key_ascii is sampled and latched as held_ascii, and {code, ascii} is pushed. The event is visible on rd_data/count at N+2 when the FIFO was empty.
- FSM (all counters reset to 0 on each entry):
  - IDLE: on press, push and go to HOLD.
  - HOLD: on release, go to IDLE with no push. On a different code, push the new key and restart HOLD. When counter == DELAY_CYC-1, push {code, held_ascii} and go to REPEAT.
  - REPEAT: when counter == PERIOD_CYC-1, push {code, held_ascii} and restart counter. Release and code change are handled as in HOLD.
- Release takes priority over a repeat push in the same cycle.
- FIFO:
  - Pop when rd_en && !empty; rd_en while empty is ignored.
  - A push is accepted if !full, or if full with a pop in the same cycle; in that case count is unchanged and FIFO order is preserved.
  - A push while full with no pop: event dropped, overflow set the next cycle.
  - Pointers wrap modulo DEPTH. full = (count == DEPTH).
- overflow: clr_ovf clears it. If clr_ovf coincides with a new drop, the flag stays set (set wins).
- Combinational paths: rd_data, empty, full and count are all register outputs; there is no combinational path from rd_en.

Optional Feature:
- KB_REPEAT_EN defined: auto-repeat FSM and counter as above.
- KB_REPEAT_EN undefined:
  - HOLD and REPEAT states and the counter are removed; exactly one event per press.
  - DELAY_CYC and PERIOD_CYC are accepted but unused.
  - Release and code-change detection are unchanged.

Test Plan:
- DEPTH=4, DELAY_CYC=8, PERIOD_CYC=4.
- Single press: key_code=8'h1C, key_en rises, key_ascii=8'h61 one cycle later, released after 3 cycles -> exactly one entry 16'h1C61; count=1 at press+2; rd_en pulse -> empty=1.
- Held key (KB_REPEAT_EN): key 8'h1C held 20 cycles -> pushes at press+1, +9, +13, +17 (4 entries, full=1); no overflow. Held past +21 with no pops -> overflow=1 at +22.
- Rollover: press 8'h1C, 3 cycles later key_code=8'h32 (ascii 8'h62) with key_en still high -> entries 16'h1C61 then 16'h3262; HOLD counter restarts on the second key.
- Full with simultaneous push and pop: FIFO full, a press push coincides with rd_en -> count stays 4, oldest entry removed, new entry at tail, overflow=0.
- Overflow clear: overflow=1; clr_ovf pulse with no drop -> 0 next cycle. clr_ovf in the same cycle as a drop -> stays 1.
- Reset mid-REPEAT: rst for 1 cycle while key held -> FIFO empty, overflow=0; one new press event pushed 2 cycles after rst deasserts.
- Without KB_REPEAT_EN: key held 50 cycles -> exactly 1 entry.

Source files
------------

// File: rtl/kb_event_ctrl_if.sv
// kb_event_ctrl_if
//   CPU-side bus of the keyboard event controller.
//   master : CPU I/O decode. It drives rd_en (pop pulse) and clr_ovf (overflow clear).
//   slave  : kb_event_ctrl. It drives rd_data (show-ahead head entry),
//            empty, full, count and overflow.
//   DEPTH must match the DEPTH of the attached kb_event_ctrl.
interface kb_event_ctrl_if #(
  parameter int DEPTH = 16
) ();
  logic                     rd_en;
  logic                     clr_ovf;
  logic [15:0]              rd_data;
  logic                     empty;
  logic                     full;
  logic [$clog2(DEPTH):0]   count;
  logic                     overflow;

  modport master (
    output rd_en, clr_ovf,
    input  rd_data, empty, full, count, overflow
  );

  modport slave (
    input  rd_en, clr_ovf,
    output rd_data, empty, full, count, overflow
  );
endinterface

// File: rtl/kb_event_ctrl.sv
// kb_event_ctrl
//   Turns the PS/2 decoder's key level (key_en/key_code/key_ascii) into a
//   buffered stream of key events {code, ascii} that the CPU pops.
//   Press edges always produce one event. With the KB_REPEAT_EN macro
//   defined, a held key also produces typematic repeats: the first repeat
//   comes DELAY_CYC cycles after the press, and further repeats follow every
//   PERIOD_CYC cycles. Without the macro, DELAY_CYC/PERIOD_CYC are ignored.
// Ports
//   clk, rst   : clock, synchronous active-high reset
//   key_code   : current key code
//   key_ascii  : ASCII of key_code, valid one cycle after key_code (sync ROM)
//   key_en     : high while a printable key is held
//   bus        : CPU side (kb_event_ctrl_if.slave). It carries rd_en/clr_ovf in,
//                and rd_data/empty/full/count/overflow out, all registered.
module kb_event_ctrl #(
  parameter int DEPTH      = 16,
  parameter int DELAY_CYC  = 25000000,
  parameter int PERIOD_CYC = 5000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       key_code,
  input  logic [7:0]       key_ascii,
  input  logic             key_en,
  kb_event_ctrl_if.slave   bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Edge detection
  logic       key_en_q;
  logic [7:0] code_q;
  logic       press;
  logic       rep_fire;

  assign press = key_en && (!key_en_q || (key_code != code_q));

  // A detected event is pushed one cycle later, when key_ascii has caught
  // up with the code latched at detection time.
  logic       pend_reg;
  logic [7:0] pend_code_reg;
  logic [15:0] push_data;

`ifdef KB_REPEAT_EN
  localparam int TMAX = (DELAY_CYC > PERIOD_CYC) ? DELAY_CYC : PERIOD_CYC;
  localparam int TW   = $clog2(TMAX) + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_REPEAT
  } state_t;

  state_t         state_reg, state_next;
  logic [TW-1:0]  cnt_reg, cnt_next;
  logic           release_w;
  logic           pend_live_reg;   // 1: press event (use live ascii), 0: repeat
  logic [7:0]     held_ascii_reg;

  assign release_w = !key_en && key_en_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Release outranks a repeat due in the same cycle; a code change restarts
  // the delay for the new key.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg + 1'b1;
    rep_fire   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        cnt_next = '0;
        if (press) state_next = ST_HOLD;
      end
      ST_HOLD: begin
        if (release_w) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else if (press) begin
          cnt_next = '0;
        end else if (cnt_reg == TW'(DELAY_CYC - 1)) begin
          state_next = ST_REPEAT;
          cnt_next   = '0;
          rep_fire   = 1'b1;
        end
      end
      ST_REPEAT: begin
        if (release_w) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else if (press) begin
          state_next = ST_HOLD;
          cnt_next   = '0;
        end else if (cnt_reg == TW'(PERIOD_CYC - 1)) begin
          cnt_next = '0;
          rep_fire = 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_live_reg  <= 1'b0;
      held_ascii_reg <= '0;
    end else begin
      pend_live_reg <= press;
      if (pend_reg && pend_live_reg) held_ascii_reg <= key_ascii;
    end
  end

  assign push_data = {pend_code_reg, pend_live_reg ? key_ascii : held_ascii_reg};
`else
  logic [31:0] unused_cfg;
  assign unused_cfg = 32'(DELAY_CYC) ^ 32'(PERIOD_CYC);
  assign rep_fire   = 1'b0;
  assign push_data  = {pend_code_reg, key_ascii};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      key_en_q      <= 1'b0;
      code_q        <= '0;
      pend_reg      <= 1'b0;
      pend_code_reg <= '0;
    end else begin
      key_en_q <= key_en;
      code_q   <= key_code;
      pend_reg <= press || rep_fire;
      if (press) pend_code_reg <= key_code;
    end
  end

  // FIFO
  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg, count_next;
  logic          empty_reg, full_reg, ovf_reg;
  logic [15:0]   rd_data_reg;
  logic          pop, push_ok, drop;

  assign pop     = bus.rd_en && !empty_reg;
  // Full plus a same-cycle pop frees the slot the push writes into.
  assign push_ok = pend_reg && (!full_reg || pop);
  assign drop    = pend_reg && full_reg && !pop;

  assign count_next = count_reg + CW'(push_ok) - CW'(pop);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      empty_reg   <= 1'b1;
      full_reg    <= 1'b0;
      ovf_reg     <= 1'b0;
      rd_data_reg <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)     rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
      empty_reg <= (count_next == '0);
      full_reg  <= (count_next == CW'(DEPTH));
      if (drop)             ovf_reg <= 1'b1;
      else if (bus.clr_ovf) ovf_reg <= 1'b0;
      // Show-ahead head register: follow the next stored entry on a pop,
      // or take the incoming entry when it becomes the head.
      if (pop) begin
        if (count_reg > CW'(1))  rd_data_reg <= mem[rd_ptr_reg + 1'b1];
        else if (push_ok)        rd_data_reg <= push_data;
      end else if (push_ok && empty_reg) begin
        rd_data_reg <= push_data;
      end
    end
  end

  assign bus.rd_data  = rd_data_reg;
  assign bus.empty    = empty_reg;
  assign bus.full     = full_reg;
  assign bus.count    = count_reg;
  assign bus.overflow = ovf_reg;

endmodule

// File: tb/tb_kb_event_ctrl.sv
`timescale 1ns/1ps
module tb_kb_event_ctrl;
  localparam int DEPTH = 4, DELAY_CYC = 8, PERIOD_CYC = 4;
  localparam int CNTW = $clog2(DEPTH) + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] key_code = '0, key_ascii = '0;
  logic       key_en = 1'b0;

  kb_event_ctrl_if #(.DEPTH(DEPTH)) bus ();

  kb_event_ctrl #(.DEPTH(DEPTH), .DELAY_CYC(DELAY_CYC), .PERIOD_CYC(PERIOD_CYC)) dut (
    .clk(clk), .rst(rst), .key_code(key_code), .key_ascii(key_ascii),
    .key_en(key_en), .bus(bus)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;

  // Decoder ASCII ROM: one cycle of latency behind key_code.
  function automatic logic [7:0] rom(input logic [7:0] c);
    case (c)
      8'h1C:   return 8'h61;
      8'h32:   return 8'h62;
      default: return c ^ 8'hA5;
    endcase
  endfunction
  always @(posedge clk) key_ascii <= rom(key_code);

  // Reference model: event times in absolute cycles, FIFO as a queue.
  logic [15:0] mq[$];
  logic        m_ovf = 0, m_prev_en = 0, m_pend = 0, m_live = 0, m_holding = 0;
  logic [7:0]  m_prev_code = 0, m_pcode = 0, m_held = 0;
  int          m_next_rep = 0, cyc = 0;

  always @(posedge clk) begin
    logic press, rel, pop, drop;
    logic [15:0] pd;
    cyc++;
    if (rst) begin
      mq.delete();
      m_ovf = 0; m_prev_en = 0; m_prev_code = 0; m_pend = 0;
      m_live = 0; m_holding = 0; m_pcode = 0; m_held = 0;
    end else begin
      drop = 0;
      pop = bus.rd_en && (mq.size() > 0);
      if (pop) void'(mq.pop_front());
      if (m_pend) begin
        pd = {m_pcode, m_live ? key_ascii : m_held};
        if (m_live) m_held = key_ascii;
        if (mq.size() < DEPTH) mq.push_back(pd);
        else drop = 1;
      end
      if (drop) m_ovf = 1;
      else if (bus.clr_ovf) m_ovf = 0;
      press = key_en && (!m_prev_en || key_code != m_prev_code);
      rel   = !key_en && m_prev_en;
      m_pend = 0;
      if (press) begin
        m_pend = 1; m_live = 1; m_pcode = key_code;
        m_holding = 1; m_next_rep = cyc + DELAY_CYC;
      end else if (rel) begin
        m_holding = 0;
      end
`ifdef KB_REPEAT_EN
      else if (m_holding && cyc == m_next_rep) begin
        m_pend = 1; m_live = 0; m_next_rep = cyc + PERIOD_CYC;
      end
`endif
      m_prev_en = key_en;
      m_prev_code = key_code;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    logic bad;
    vectors++;
    bad = (bus.count !== CNTW'(mq.size())) || (bus.empty !== (mq.size() == 0)) ||
          (bus.full !== (mq.size() == DEPTH)) || (bus.overflow !== m_ovf) ||
          ((mq.size() > 0) && (bus.rd_data !== mq[0]));
    if (bad) begin
      miscompares++;
      $display("FAIL model_cycle t=%0t: got count=%0d empty=%b full=%b ovf=%b data=%h, required count=%0d empty=%b full=%b ovf=%b data=%h",
               $time, bus.count, bus.empty, bus.full, bus.overflow, bus.rd_data,
               mq.size(), mq.size() == 0, mq.size() == DEPTH, m_ovf,
               (mq.size() > 0) ? mq[0] : 16'h0);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic pop_one(input string name, input logic [15:0] exp);
    check(name, bus.rd_data, exp);
    $display("pop %s data=%h", name, bus.rd_data);
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
  endtask

  task automatic press_release(input logic [7:0] c, input int hold);
    key_code = c; key_en = 1'b1;
    repeat (hold) tick();
    key_en = 1'b0;
    repeat (2) tick();
  endtask

  initial begin
    bus.rd_en = 1'b0; bus.clr_ovf = 1'b0;
    repeat (2) tick();
    check("rst_count", 16'(bus.count), 16'd0);
    check("rst_empty", 16'(bus.empty), 16'd1);
    check("rst_full", 16'(bus.full), 16'd0);
    check("rst_ovf", 16'(bus.overflow), 16'd0);
    check("rst_data", bus.rd_data, 16'h0000);
    rst = 1'b0;
    tick();

    // Single press
    key_code = 8'h1C; key_en = 1'b1;
    repeat (2) tick();
    check("single_count_p2", 16'(bus.count), 16'd1);
    check("single_data", bus.rd_data, 16'h1C61);
    tick();
    key_en = 1'b0;
    repeat (2) tick();
    check("single_count_end", 16'(bus.count), 16'd1);
    pop_one("single", 16'h1C61);
    check("single_empty", 16'(bus.empty), 16'd1);

    // Rollover to a second key while held
    key_code = 8'h1C; key_en = 1'b1;
    repeat (3) tick();
    key_code = 8'h32;
    repeat (6) tick();
    key_en = 1'b0;
    repeat (3) tick();
    check("roll_count", 16'(bus.count), 16'd2);
    pop_one("roll0", 16'h1C61);
    pop_one("roll1", 16'h3262);
    check("roll_empty", 16'(bus.empty), 16'd1);

`ifdef KB_REPEAT_EN
    key_code = 8'h1C; key_en = 1'b1;
    repeat (20) tick();
    check("rep_count", 16'(bus.count), 16'd4);
    check("rep_full", 16'(bus.full), 16'd1);
    check("rep_no_ovf", 16'(bus.overflow), 16'd0);
    repeat (2) tick();
    check("rep_ovf", 16'(bus.overflow), 16'd1);
    key_en = 1'b0;
    tick();
`else
    key_code = 8'h1C; key_en = 1'b1;
    repeat (50) tick();
    key_en = 1'b0;
    repeat (2) tick();
    check("norep_count", 16'(bus.count), 16'd1);
    repeat (3) press_release(8'h1C, 2);
    check("norep_full", 16'(bus.full), 16'd1);
    press_release(8'h1C, 2);
    check("norep_ovf", 16'(bus.overflow), 16'd1);
`endif

    // Overflow clear, then clear colliding with a drop
    bus.clr_ovf = 1'b1; tick(); bus.clr_ovf = 1'b0;
    check("clr_ovf", 16'(bus.overflow), 16'd0);
    key_code = 8'h1C; key_en = 1'b1;
    tick();
    bus.clr_ovf = 1'b1; tick(); bus.clr_ovf = 1'b0;
    check("clr_vs_drop", 16'(bus.overflow), 16'd1);
    key_en = 1'b0;
    repeat (2) tick();
    bus.clr_ovf = 1'b1; tick(); bus.clr_ovf = 1'b0;
    check("clr_ovf2", 16'(bus.overflow), 16'd0);

    // Full FIFO: push and pop in the same cycle
    key_code = 8'h32; key_en = 1'b1;
    tick();
    bus.rd_en = 1'b1; tick(); bus.rd_en = 1'b0;
    check("pp_count", 16'(bus.count), 16'd4);
    check("pp_ovf", 16'(bus.overflow), 16'd0);
    key_en = 1'b0;
    repeat (2) tick();
    for (int i = 0; i < 3; i++) pop_one("pp_old", 16'h1C61);
    pop_one("pp_new", 16'h3262);
    check("pp_empty", 16'(bus.empty), 16'd1);

    // Reset while a key is held
    key_code = 8'h1C; key_en = 1'b1;
    repeat (12) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    check("mid_rst_empty", 16'(bus.empty), 16'd1);
    check("mid_rst_ovf", 16'(bus.overflow), 16'd0);
    repeat (2) tick();
    check("mid_rst_count", 16'(bus.count), 16'd1);
    check("mid_rst_data", bus.rd_data, 16'h1C61);
    key_en = 1'b0;
    tick();
    pop_one("mid_rst", 16'h1C61);

    // Randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      if (key_en) begin
        if ($urandom_range(0, 9) == 0) key_en = 1'b0;
        else if ($urandom_range(0, 11) == 0) key_code = 8'h10 + 8'($urandom_range(0, 3));
      end else if ($urandom_range(0, 5) == 0) begin
        key_en = 1'b1;
        key_code = ($urandom_range(0, 1) == 0) ? 8'h1C : 8'h10 + 8'($urandom_range(0, 3));
      end
      bus.rd_en   = ($urandom_range(0, 4) == 0);
      bus.clr_ovf = ($urandom_range(0, 19) == 0);
      tick();
    end
    bus.rd_en = 1'b0; bus.clr_ovf = 1'b0; key_en = 1'b0;
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
